// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// reset/bubble constants and the j/jal target helper also used by ID/EX.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] addr26);
    return {pc_plus4[31:28], addr26, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port: one request at a time, accepted on imem_ready,
// answered later by a single imem_rvalid beat.
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush -> bubble, hold -> keep,
// load -> new instruction, otherwise bubble.
module if_stage_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i || (!hold_i && !load_i)) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      instr_d = instr_i;
      pc4_d   = pc_plus4_i;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding fetch FSM with a
// one-word hold buffer for stalls, branch/jump redirect, and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  imem,
  input  logic        stall_id,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [25:0] jump_address,
  output logic [31:0] pc_if,
  output logic [31:0] instruction_if_id,
  output logic [31:0] pc_plus4_if_id,
  output logic        valid_if_id
);

  import if_stage_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         drop_q, drop_d;

  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  pc_plus4;
  logic         ifid_load;
  logic [31:0]  ifid_word;

  // The branch is the older instruction, so it outranks a jump in ID.
  assign redirect    = branch_taken | jump_taken;
  assign redirect_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC)
                                    : jump_target(pc_plus4_if_id, jump_address);
  assign pc_plus4    = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    drop_d         = drop_q;
    imem.imem_req  = 1'b0;
    ifid_load      = 1'b0;
    ifid_word      = imem.imem_rdata;

    unique case (state_q)
      S_REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect;
        end
      end

      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            if (stall_id) begin
              hold_d  = imem.imem_rdata;
              state_d = S_HOLD;
            end else begin
              ifid_load = 1'b1;
            end
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall_id) begin
          ifid_load = 1'b1;
          ifid_word = hold_q;
          state_d   = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase

    if (redirect) begin
      pc_d = redirect_pc;
    end else if (ifid_load) begin
      pc_d = pc_plus4;
    end
  end

  // NOTE: the hold buffer is a single word of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign pc_if          = pc_q;

  if_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .hold_i     (stall_id),
    .load_i     (ifid_load),
    .instr_i    (ifid_word),
    .pc_plus4_i (pc_plus4),
    .instr_o    (instruction_if_id),
    .pc_plus4_o (pc_plus4_if_id),
    .valid_o    (valid_if_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id, branch_taken, jump_taken;
  logic [31:0] branch_target;
  logic [25:0] jump_address;
  logic [31:0] pc_if, instruction_if_id, pc_plus4_if_id;
  logic        valid_if_id;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (bus),
    .stall_id          (stall_id),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump_taken        (jump_taken),
    .jump_address      (jump_address),
    .pc_if             (pc_if),
    .instruction_if_id (instruction_if_id),
    .pc_plus4_if_id    (pc_plus4_if_id),
    .valid_if_id       (valid_if_id)
  );

  // Reference model: fetch PC, whether a request is outstanding (and whether
  // it went stale), a parked word, and the IF/ID contents.
  logic [31:0] m_pc, m_addr, m_word, m_instr, m_pc4;
  logic        m_busy, m_stale, m_held, m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_word = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0;
    m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic        redir, deliver;
    logic [31:0] tgt, w;
    redir   = branch_taken | jump_taken;
    tgt     = branch_taken ? {branch_target[31:2], 2'b00}
                           : {m_pc4[31:28], jump_address, 2'b00};
    deliver = 1'b0;
    w       = 32'h0;
    if (!m_busy && !m_held) begin
      if (bus.imem_ready) begin
        m_busy  = 1'b1;
        m_stale = redir;
        m_addr  = m_pc;
      end
    end else if (m_busy) begin
      if (bus.imem_rvalid) begin
        m_busy = 1'b0;
        if (m_stale || redir) m_stale = 1'b0;
        else if (stall_id) begin
          m_held = 1'b1;
          m_word = bus.imem_rdata;
        end else begin
          deliver = 1'b1;
          w       = bus.imem_rdata;
        end
      end else if (redir) begin
        m_stale = 1'b1;
      end
    end else begin
      if (redir) m_held = 1'b0;
      else if (!stall_id) begin
        m_held  = 1'b0;
        deliver = 1'b1;
        w       = m_word;
      end
    end
    if (redir) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else if (!stall_id) begin
      if (deliver) begin
        m_valid = 1'b1; m_instr = w; m_pc4 = m_pc + 32'd4;
      end else begin
        m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      end
    end
    if (redir) m_pc = tgt;
    else if (deliver) m_pc = m_pc + 32'd4;
  endtask

  task automatic check_outputs();
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, !m_busy && !m_held});
    check("imem_addr", bus.imem_addr, m_pc);
    check("pc_if", pc_if, m_pc);
    check("valid_if_id", {31'b0, valid_if_id}, {31'b0, m_valid});
    check("instruction_if_id", instruction_if_id, m_instr);
    check("pc_plus4_if_id", pc_plus4_if_id, m_pc4);
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic br, input logic [31:0] bt,
                       input logic jt, input logic [25:0] ja);
    bus.imem_ready  = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    stall_id        = st;
    branch_taken    = br;
    branch_target   = bt;
    jump_taken      = jt;
    jump_address    = ja;
  endtask

  // Called one time unit after a rising edge; ends one time unit after the next.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc_if, 32'h0);
    check({tag, "_addr"}, bus.imem_addr, 32'h0);
    check({tag, "_req"}, {31'b0, bus.imem_req}, 32'h1);
    check({tag, "_valid"}, {31'b0, valid_if_id}, 32'h0);
    check({tag, "_instr"}, instruction_if_id, 32'h0);
    check({tag, "_pc4"}, pc_plus4_if_id, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    model_reset();
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First fetch at pc 0, response one cycle after acceptance.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t1_valid", {31'b0, valid_if_id}, 32'h1);
    check("t1_instr", instruction_if_id, 32'h2008_0005);
    check("t1_pc4", pc_plus4_if_id, 32'h4);
    check("t1_next_addr", bus.imem_addr, 32'h4);
    check("t1_next_req", {31'b0, bus.imem_req}, 32'h1);

    // Stall while the response arrives: word parks in the hold buffer.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t2_hold_instr", instruction_if_id, 32'h2008_0005);
    check("t2_hold_req", {31'b0, bus.imem_req}, 32'h0);
    check("t2_hold_pc", pc_if, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t2_release_instr", instruction_if_id, 32'hAABB_CCDD);
    check("t2_release_pc", pc_if, 32'h8);

    // Jump while a request is outstanding: the late word must be dropped.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_000C, 1'b0, 26'h0);
    cycle();
    check("t3_branch_addr", bus.imem_addr, 32'h4000_000C);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t3_pc4", pc_plus4_if_id, 32'h4000_0010);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100);
    cycle();
    check("t3_jump_valid", {31'b0, valid_if_id}, 32'h0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t3_drop_valid", {31'b0, valid_if_id}, 32'h0);
    check("t3_drop_instr", instruction_if_id, 32'h0);
    check("t3_jump_addr", bus.imem_addr, 32'h4000_0400);
    check("t3_jump_req", {31'b0, bus.imem_req}, 32'h1);

    // Branch and jump together under stall: branch wins, IF/ID flushed.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t4_stalled_valid", {31'b0, valid_if_id}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 26'h3FF_FFFF);
    cycle();
    check("t4_addr", bus.imem_addr, 32'h0000_0080);
    check("t4_valid", {31'b0, valid_if_id}, 32'h0);
    check("t4_instr", instruction_if_id, 32'h0);

    // PC wrap from the top of the address space.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h5555_6666, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t5_pc", pc_if, 32'h0);
    check("t5_pc4", pc_plus4_if_id, 32'h0);
    check("t5_valid", {31'b0, valid_if_id}, 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r_bt, r_ja, r_rd;
      logic        r_rv;
      r_bt = $urandom;
      r_ja = $urandom;
      r_rv = m_busy && ($urandom_range(0, 2) != 0);
      r_rd = r_rv ? mem_word(m_addr) : $urandom;
      drive($urandom_range(0, 1) == 1, r_rv, r_rd,
            $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, r_bt,
            $urandom_range(0, 11) == 0, r_ja[25:0]);
      cycle();
    end

    // Drain back to the request state.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, m_busy, mem_word(m_addr), 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      cycle();
    end

    // Reach the hold state, then reset asynchronously mid-cycle.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 26'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h7777_8888, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, 32'h9999_AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t6_hold_req", {31'b0, bus.imem_req}, 32'h0);
    check("t6_hold_pc", pc_if, 32'h0000_1004);
    check("t6_hold_valid", {31'b0, valid_if_id}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    drive(1'b0, 1'b1, mem_word(m_addr), 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle();
    check("t6_refetch_instr", instruction_if_id, mem_word(32'h0));
    check("t6_refetch_pc", pc_if, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the MIPS pipeline.
- Holds the PC and fetches words from instruction memory over a req/ready + rvalid handshake.
- Applies branch/jump redirects and honours hazard stalls.
- Drives instruction_if_id, pc_plus4_if_id and valid_if_id into the ID-stage field decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) driven on instruction_if_id when invalid.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch byte address, equal to pc_if.
- imem_ready  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  fetched instruction word.
- stall_id  input  1  hazard unit: hold IF/ID contents and PC.
- branch_taken  input  1  branch resolved taken this cycle.
- branch_target  input  32  branch target; bits [1:0] ignored.
- jump_taken  input  1  ID stage decoded j/jal this cycle.
- jump_address  input  26  jump field from the ID decoder.
- pc_if  output  32  current fetch PC.
- instruction_if_id  output  32  IF/ID instruction register.
- pc_plus4_if_id  output  32  IF/ID PC+4 of that instruction.
- valid_if_id  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, active-high):
  - pc_if = RESET_PC; state = S_REQ; imem_req = 1 on the first cycle after reset.
  - instruction_if_id = NOP_INSTR; pc_plus4_if_id = 0; valid_if_id = 0; hold buffer cleared; drop flag = 0.
  - Instruction memory shares rst, so no response is outstanding after reset.
- State S_REQ:
  - Drive imem_req = 1, imem_addr = pc_if.
  - On imem_ready go to S_WAIT.
- State S_WAIT:
  - imem_req = 0.
  - On imem_rvalid with drop = 0 and stall_id = 0: load IF/ID, pc_if <= pc_if + 4, go to S_REQ.
  - On imem_rvalid with drop = 0 and stall_id = 1: latch imem_rdata into the hold buffer, go to S_HOLD.
  - On imem_rvalid with drop = 1: discard the word, clear drop, go to S_REQ. pc_if was already redirected.
- State S_HOLD:
  - imem_req = 0.
  - When stall_id = 0: load IF/ID from the hold buffer, pc_if <= pc_if + 4, go to S_REQ.
- Throughput: at best one instruction per 2 cycles (single outstanding request).
- Redirect:
  - Active when branch_taken or jump_taken.
  - branch_taken has priority over jump_taken, because the branch belongs to the older instruction.
  - Target: branch gives {branch_target[31:2], 2'b00}; jump gives {pc_plus4_if_id[31:28], jump_address, 2'b00}.
  - On redirect: pc_if <= target; IF/ID <= bubble (valid_if_id = 0, instruction_if_id = NOP_INSTR). Flush beats stall_id.
  - In S_REQ without handshake: stay in S_REQ; the new address is presented next cycle.
  - In S_REQ with imem_ready the same cycle: the accepted request is stale; go to S_WAIT with drop = 1.
  - In S_WAIT before rvalid: set drop = 1.
  - In S_WAIT with rvalid the same cycle: discard the word, go to S_REQ.
  - In S_HOLD: discard the hold buffer, go to S_REQ.
- IF/ID update priority each cycle: redirect -> bubble; else stall_id -> hold all three registers; else new instruction available -> load with valid = 1; else bubble.
- PC:
  - Advances only when an instruction enters IF/ID, or on redirect.
  - Wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - bits [1:0] are always 00.
- pc_plus4_if_id is the loaded instruction's PC + 4, captured with the instruction.

Decomposition:
- Shared package:
  - fetch state enum (S_REQ, S_WAIT, S_HOLD).
  - NOP_INSTR and RESET_PC constants.
  - function jump_target(pc_plus4, addr26) reused by the ID/EX logic.
- One sub-module is natural: if_id_reg, the IF/ID register with load/hold/flush controls. The FSM and PC stay in if_stage.

Test Plan:
- Reset then imem_ready = 1 and rvalid one cycle after acceptance, returning 32'h2008_0005 at pc 0 -> valid_if_id = 1, instruction_if_id = 32'h2008_0005, pc_plus4_if_id = 4; the next request has imem_addr = 4.
- stall_id = 1 when rvalid returns 32'hAABB_CCDD (hold buffer) -> IF/ID unchanged and no imem_req while stalled; one cycle after stall_id drops, instruction_if_id = 32'hAABB_CCDD and pc_if advances by 4.
- jump_taken with pc_plus4_if_id = 32'h4000_0010 and jump_address = 26'h000_0100, while a request is in S_WAIT -> the late response is dropped, valid_if_id = 0, and the next imem_addr = 32'h4000_0400.
- branch_taken (target 32'h0000_0080) together with jump_taken -> next imem_addr = 32'h0000_0080 and IF/ID is a bubble even with stall_id = 1.
- pc_if = 32'hFFFF_FFFC, fetch completes -> pc_if = 0 and pc_plus4_if_id = 0.
- Assert rst while in S_HOLD -> outputs immediately return to the reset values, with no clock edge needed.
